// File: rtl/cla_adder_pipe_pkg.sv
// Shared types for the pipelined carry-lookahead adder: block width and
// propagate/generate pair with its lookahead combine operator.
package cla_pkg;

    localparam int unsigned BLK = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result stream bundle of cla_adder_pipe; slave side is the adder.
interface cla_adder_pipe_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             gp;
    logic             gg;

    modport slave (
        input  in_valid, in_a, in_b, cin, in_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, gp, gg
    );

    modport master (
        output in_valid, in_a, in_b, cin, in_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, gp, gg
    );
endinterface

// File: rtl/cla_adder_pipe_block4.sv
// 4-bit carry-lookahead block: sum plus block propagate/generate for the
// second lookahead level.
module cla_block4
    import cla_pkg::*;
(
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           c_in,
    output logic [BLK-1:0] s,
    output pg_t            pg
);
    logic [BLK-1:0] w_p;
    logic [BLK-1:0] w_g;
    logic [BLK-1:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);

    assign s    = w_p ^ w_c;
    assign pg.p = &w_p;
    assign pg.g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder, one WIDTH/STAGES segment per stage, with a
// valid/ready stream and global stall. Define CLA_SUB_EN to add in_sub subtract.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_adder_pipe_if.slave   bus
);
    localparam int unsigned SEG = WIDTH / STAGES;
    localparam int unsigned NB  = SEG / BLK;

    if (STAGES < 1 || STAGES > 8 || (WIDTH % (BLK * STAGES)) != 0) begin : g_param_err
        $error("cla_adder_pipe: need STAGES in 1..8 and WIDTH a multiple of 4*STAGES");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;

`ifdef CLA_SUB_EN
    assign w_b0 = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign w_c0 = bus.in_sub | bus.cin;
`else
    assign w_b0 = bus.in_b;
    assign w_c0 = bus.cin;
`endif

    assign w_adv        = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = w_adv;

    // Stage k keeps only finished low bits and the not-yet-added high operands.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned REM  = WIDTH - (k + 1) * SEG;
        localparam int unsigned DONE = (k + 1) * SEG;

        logic [SEG-1:0]  w_sa, w_sb, w_seg;
        logic            w_vin, w_cin, w_gpin, w_ggin;
        logic [DONE-1:0] w_nsum;
        logic [NB:0]     w_bc;
        pg_t  [NB-1:0]   w_blk, w_pref;

        logic            r_vld, r_c, r_gp, r_gg;
        logic [DONE-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_vin  = bus.in_valid;
            assign w_sa   = bus.in_a[SEG-1:0];
            assign w_sb   = w_b0[SEG-1:0];
            assign w_cin  = w_c0;
            assign w_gpin = 1'b1;
            assign w_ggin = 1'b0;
            assign w_nsum = w_seg;
        end else begin : g_src
            assign w_vin  = g_stage[k-1].r_vld;
            assign w_sa   = g_stage[k-1].g_rest.r_a[SEG-1:0];
            assign w_sb   = g_stage[k-1].g_rest.r_b[SEG-1:0];
            assign w_cin  = g_stage[k-1].r_c;
            assign w_gpin = g_stage[k-1].r_gp;
            assign w_ggin = g_stage[k-1].r_gg;
            assign w_nsum = {w_seg, g_stage[k-1].r_sum};
        end

        assign w_bc[0] = w_cin;
        for (genvar j = 0; j < NB; j++) begin : g_blk
            cla_block4 u_blk (
                .a    (w_sa[j*BLK +: BLK]),
                .b    (w_sb[j*BLK +: BLK]),
                .c_in (w_bc[j]),
                .s    (w_seg[j*BLK +: BLK]),
                .pg   (w_blk[j])
            );
            if (j == 0) begin : g_pref
                assign w_pref[j] = w_blk[j];
            end else begin : g_pref
                assign w_pref[j] = pg_combine(w_blk[j], w_pref[j-1]);
            end
            assign w_bc[j+1] = w_pref[j].g | (w_pref[j].p & w_cin);
        end

        if (REM > 0) begin : g_rest
            logic [REM-1:0] w_ra, w_rb, r_a, r_b;
            if (k == 0) begin : g_rsrc
                assign w_ra = bus.in_a[WIDTH-1:SEG];
                assign w_rb = w_b0[WIDTH-1:SEG];
            end else begin : g_rsrc
                assign w_ra = g_stage[k-1].g_rest.r_a[REM+SEG-1:SEG];
                assign w_rb = g_stage[k-1].g_rest.r_b[REM+SEG-1:SEG];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_ra;
                    r_b <= w_rb;
                end
            end
        end

        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     r_ovf <= 1'b0;
                else if (w_adv) r_ovf <= w_sa[SEG-1] ^ w_sb[SEG-1] ^ w_seg[SEG-1] ^ w_bc[NB];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_gp  <= 1'b0;
                r_gg  <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
                r_c   <= w_bc[NB];
                r_gp  <= w_pref[NB-1].p & w_gpin;
                r_gg  <= w_pref[NB-1].g | (w_pref[NB-1].p & w_ggin);
                r_sum <= w_nsum;
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_vld;
    assign bus.sum       = g_stage[STAGES-1].r_sum;
    assign bus.cout      = g_stage[STAGES-1].r_c;
    assign bus.gp        = g_stage[STAGES-1].r_gp;
    assign bus.gg        = g_stage[STAGES-1].r_gg;
    assign bus.ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe (WIDTH=64, STAGES=4); honours CLA_SUB_EN.
module tb_cla_adder_pipe;
    localparam int unsigned W = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [W:0]   q[$];
    logic [W-1:0] ra, rb;
    logic         rc;
    int           sent, got, first, last, vcount;

    cla_adder_pipe_if #(.WIDTH(W)) bus ();

    cla_adder_pipe #(.WIDTH(W), .STAGES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input logic [W:0] exp_cs,
                          input logic exp_gp, input logic exp_gg, input logic exp_ovf);
        bus.in_a = a; bus.in_b = b; bus.cin = c; bus.in_sub = s; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk({tag, ".early"}, (W+1)'(bus.out_valid), (W+1)'(0));
        tick();
        chk({tag, ".valid"}, (W+1)'(bus.out_valid), (W+1)'(1));
        chk({tag, ".cs"},    {bus.cout, bus.sum},    exp_cs);
        chk({tag, ".gp"},    (W+1)'(bus.gp),         (W+1)'(exp_gp));
        chk({tag, ".gg"},    (W+1)'(bus.gg),         (W+1)'(exp_gg));
        chk({tag, ".ovf"},   (W+1)'(bus.ovf),        (W+1)'(exp_ovf));
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.cin = 1'b0;
        bus.in_sub = 1'b0;   bus.out_ready = 1'b1;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst.out_valid", (W+1)'(bus.out_valid), (W+1)'(0));
        chk("rst.cs",        {bus.cout, bus.sum},    (W+1)'(0));
        chk("rst.gp",        (W+1)'(bus.gp),         (W+1)'(0));
        chk("rst.gg",        (W+1)'(bus.gg),         (W+1)'(0));
        chk("rst.ovf",       (W+1)'(bus.ovf),        (W+1)'(0));
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready",  (W+1)'(bus.in_ready),   (W+1)'(1));

        // Directed vectors; a^b all-ones in t1 gives gp=1.
        run_op("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
               {1'b1, 64'h0}, 1'b1, 1'b0, 1'b0);
        run_op("t2", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               {1'b0, 64'h8000_0000_0000_0000}, 1'b0, 1'b0, 1'b1);
        run_op("zero_cin", 64'h0, 64'h0, 1'b1, 1'b0,
               {1'b0, 64'h1}, 1'b0, 1'b0, 1'b0);
        run_op("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
               {1'b1, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0, 1'b1, 1'b0);
        run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
               {1'b1, 64'h0}, 1'b0, 1'b1, 1'b1);
        run_op("chain", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0,
               {1'b1, 64'h0}, 1'b1, 1'b0, 1'b0);
        run_op("seg_edge", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
               {1'b0, 64'h0000_0001_0000_0000}, 1'b0, 1'b0, 1'b0);
`ifdef CLA_SUB_EN
        run_op("sub_neg", 64'd5, 64'd7, 1'b1, 1'b1,
               {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0, 1'b0, 1'b0);
        run_op("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1,
               {1'b1, 64'h2}, 1'b0, 1'b1, 1'b0);
`else
        run_op("sub_ignored", 64'd5, 64'd7, 1'b0, 1'b1,
               {1'b0, 64'd12}, 1'b0, 1'b0, 1'b0);
`endif
        bus.in_sub = 1'b0;
        tick();

        // Back-to-back random stream at full throughput.
        q.delete(); sent = 0; got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() > 0) chk("rand.res", {bus.cout, bus.sum}, q.pop_front());
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (sent < 10) begin
                ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
                rc = 1'($urandom_range(0, 1));
                bus.in_a = ra; bus.in_b = rb; bus.cin = rc; bus.in_valid = 1'b1;
                q.push_back((W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
                chk("rand.in_ready", (W+1)'(bus.in_ready), (W+1)'(1));
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        chk("rand.count",  (W+1)'(got),              (W+1)'(10));
        chk("rand.contig", (W+1)'(last - first + 1), (W+1)'(10));

        // Fill the pipe while the consumer is stalled, then drain.
        q.delete(); got = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            bus.in_a = ra; bus.in_b = rb; bus.cin = rc; bus.in_valid = 1'b1;
            q.push_back((W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall.in_ready",  (W+1)'(bus.in_ready),  (W+1)'(0));
            chk("stall.out_valid", (W+1)'(bus.out_valid), (W+1)'(1));
            chk("stall.frozen",    {bus.cout, bus.sum},    q[0]);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() > 0) chk("drain.res", {bus.cout, bus.sum}, q.pop_front());
                got++;
            end
            tick();
        end
        chk("drain.count", (W+1)'(got), (W+1)'(4));

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            bus.in_a = {$urandom, $urandom}; bus.in_b = {$urandom, $urandom};
            bus.cin = 1'b1; bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst2.async_sum", {bus.cout, bus.sum}, (W+1)'(0));
        tick();
        chk("rst2.out_valid", (W+1)'(bus.out_valid), (W+1)'(0));
        chk("rst2.sum",       {bus.cout, bus.sum},    (W+1)'(0));
        rst_n = 1'b1;
        vcount = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            if (bus.out_valid) vcount++;
        end
        chk("rst2.no_stale", (W+1)'(vcount),       (W+1)'(0));
        chk("rst2.in_ready", (W+1)'(bus.in_ready), (W+1)'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
